// File: rtl/cv32e40p_sec_marker_stream_inserter.sv
// Security marker inserter between fetch and decode; registered one-entry output slot.
// Optional CV32E40P_SEC_MARKER_RVC_EN also treats compressed jumps/branches as discontinuities.
module cv32e40p_sec_marker_stream_inserter #(
    parameter int unsigned WWDL   = 8,
    parameter int unsigned GUARD  = 2,
    parameter logic [31:0] MARKER = 32'h0000006F,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    output logic [31:0]       instr_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              flush_i,
    output logic              marker_o,
    output logic [STAT_W-1:0] marker_count_o
);

    localparam int unsigned CW = $clog2(WWDL + 1);

    generate
        if (WWDL < GUARD + 2 || WWDL > 255) begin : g_bad_wwdl
            $error("WWDL out of legal range GUARD+2..255");
        end
    endgenerate

    typedef enum logic {RUN, HOLD} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       slot_q, slot_d;
    logic              valid_q, valid_d;
    logic              marker_q, marker_d;
    logic [STAT_W-1:0] count_q, count_d;

    logic slot_free;
    logic is_disc;
    logic nonzero;
    logic need_mark;
    logic ready;

    assign slot_free = !valid_q || instr_ready_i;
    assign nonzero   = instr_i != 32'h0;

    always_comb begin
        is_disc = 1'b0;
        if (instr_i[1:0] == 2'b11) begin
            is_disc = (instr_i[6:2] == 5'b11000) ||
                      (instr_i[6:2] == 5'b11011) ||
                      (instr_i[6:2] == 5'b11001 && instr_i[14:12] == 3'b000);
        end
`ifdef CV32E40P_SEC_MARKER_RVC_EN
        else if (instr_i[1:0] == 2'b01) begin
            is_disc = (instr_i[15:13] == 3'b101) || (instr_i[15:13] == 3'b001) ||
                      (instr_i[15:13] == 3'b110) || (instr_i[15:13] == 3'b111);
        end else if (instr_i[1:0] == 2'b10) begin
            is_disc = (instr_i[15:13] == 3'b100) && (instr_i[6:2] == 5'd0) &&
                      (instr_i[11:7] != 5'd0);
        end
`endif
    end

    assign need_mark = nonzero &&
                       (cnt_q == '0 || (is_disc && cnt_q <= CW'(GUARD)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        valid_d  = valid_q && !instr_ready_i;
        marker_d = marker_q;
        count_d  = count_q;
        ready    = 1'b0;
        if (flush_i) begin
            valid_d  = 1'b0;
            marker_d = 1'b0;
            cnt_d    = CW'(WWDL);
            state_d  = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    ready = slot_free && !need_mark;
                    if (instr_valid_i && slot_free && need_mark) begin
                        // input stays pending upstream; HOLD accepts it next
                        slot_d   = MARKER;
                        valid_d  = 1'b1;
                        marker_d = 1'b1;
                        cnt_d    = CW'(WWDL);
                        count_d  = (&count_q) ? count_q : count_q + STAT_W'(1);
                        state_d  = HOLD;
                    end else if (instr_valid_i && ready) begin
                        slot_d   = instr_i;
                        valid_d  = 1'b1;
                        marker_d = 1'b0;
                        if (nonzero) cnt_d = cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    ready = slot_free;
                    if (instr_valid_i && ready) begin
                        slot_d   = instr_i;
                        valid_d  = 1'b1;
                        marker_d = 1'b0;
                        cnt_d    = nonzero ? CW'(WWDL - 1) : CW'(WWDL);
                        state_d  = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= CW'(WWDL - 2);
            slot_q   <= '0;
            valid_q  <= 1'b0;
            marker_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            marker_q <= marker_d;
            count_q  <= count_d;
        end
    end

    assign instr_ready_o  = ready && rst_n;
    assign instr_o        = slot_q;
    assign instr_valid_o  = valid_q;
    assign marker_o       = marker_q;
    assign marker_count_o = count_q;

endmodule

// File: tb/tb_cv32e40p_sec_marker_stream_inserter.sv
// Bench for the marker inserter: directed plan steps then random traffic vs a
// transaction-level window model.
module tb_cv32e40p_sec_marker_stream_inserter;

    localparam int W = 4;
    localparam int G = 2;
    localparam logic [31:0] MK   = 32'h0000006F;
    localparam logic [31:0] ADDI = 32'h00100093;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        marker_o;
    logic [15:0] marker_count_o;

    cv32e40p_sec_marker_stream_inserter #(
        .WWDL(W), .GUARD(G), .MARKER(MK), .STAT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_i(instr_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .flush_i(flush_i), .marker_o(marker_o), .marker_count_o(marker_count_o)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // model: remaining budget, whether the front word already got its marker, slot image
    int          m_budget = 0;
    bit          m_marked = 0;
    bit          m_valid = 0;
    bit          m_mark = 0;
    logic [31:0] m_word = '0;
    int          m_count = 0;
    bit          m_acc = 0;
    logic [31:0] cur_word = '0;

    function automatic bit disc(logic [31:0] w);
        logic [2:0] c3;
        c3 = w[15:13];
        if (w[1:0] == 2'b11)
            return (w[6:2] == 5'b11000) || (w[6:2] == 5'b11011) ||
                   (w[6:2] == 5'b11001 && w[14:12] == 3'd0);
`ifdef CV32E40P_SEC_MARKER_RVC_EN
        if (w[1:0] == 2'b01)
            return c3 == 3'd5 || c3 == 3'd1 || c3 == 3'd6 || c3 == 3'd7;
        if (w[1:0] == 2'b10)
            return c3 == 3'd4 && w[6:2] == 5'd0 && w[11:7] != 5'd0;
`endif
        c3 = 3'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] gen();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h00000063;
            2: return 32'h0040006F;
            3: return 32'h00008067;
            4: return 32'h00009067;
            5: return 32'h0000A001;
            6: return 32'h00008082;
            7: return 32'h00000505;
            8: return $urandom();
            default: return ADDI;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input bit rdy, input bit fl, input bit rs);
        bit free, want, exp_rdy;
        rst_n = rs;
        instr_valid_i = v;
        instr_i = cur_word;
        instr_ready_i = rdy;
        flush_i = fl;
        #1;
        free = !m_valid || rdy;
        want = cur_word != 0 && !m_marked &&
               (m_budget == 0 || (disc(cur_word) && m_budget <= G));
        exp_rdy = rs && free && !fl && !want;
        chk("ready_o", {31'd0, instr_ready_o}, {31'd0, exp_rdy});
        m_acc = 0;
        if (!rs) begin
            m_budget = W - 2; m_marked = 0; m_valid = 0;
            m_mark = 0; m_word = '0; m_count = 0;
        end else if (fl) begin
            m_valid = 0; m_mark = 0; m_budget = W; m_marked = 0;
        end else if (v && free && want) begin
            m_word = MK; m_valid = 1; m_mark = 1; m_marked = 1; m_budget = W;
            if (m_count < 65535) m_count++;
        end else if (v && free) begin
            m_word = cur_word; m_valid = 1; m_mark = 0; m_marked = 0; m_acc = 1;
            if (cur_word != 0) m_budget--;
        end else if (rdy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("valid_o", {31'd0, instr_valid_o}, {31'd0, m_valid});
        if (m_valid) begin
            chk("instr_o", instr_o, m_word);
            chk("marker_o", {31'd0, marker_o}, {31'd0, m_mark});
        end
        chk("marker_count_o", {16'd0, marker_count_o}, m_count);
    endtask

    task automatic send(input logic [31:0] w);
        cur_word = w;
        m_acc = 0;
        for (int i = 0; i < 10 && !m_acc; i++) step(1, 1, 0, 1);
        chk("send_timeout", {31'd0, m_acc}, 32'd1);
    endtask

    initial begin
        bit nw;
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_instr_o", instr_o, 32'h0);
        chk("rst_marker_o", {31'd0, marker_o}, 32'd0);

        for (int i = 0; i < 10; i++) send(ADDI);
        chk("count_after_10", {16'd0, marker_count_o}, 32'd2);

        send(ADDI);
        send(ADDI);
        send(32'h00000063);
        chk("count_after_beq", {16'd0, marker_count_o}, 32'd4);

        send(32'h00008067);
        send(ADDI);
        send(32'h00009067);
        chk("count_after_jalr", {16'd0, marker_count_o}, 32'd4);

        cur_word = ADDI;
        step(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1);
            chk("stall_marker", instr_o, MK);
        end
        send(ADDI);
        chk("after_stall_word", instr_o, ADDI);

        for (int i = 0; i < 3; i++) send(ADDI);
        cur_word = ADDI;
        step(1, 1, 0, 1);
        chk("hold_marker", {31'd0, marker_o}, 32'd1);
        step(1, 0, 1, 1);
        chk("flush_valid", {31'd0, instr_valid_o}, 32'd0);
        for (int i = 0; i < 4; i++) send(ADDI);
        chk("count_after_flush", {16'd0, marker_count_o}, 32'd6);
        send(ADDI);
        chk("count_window", {16'd0, marker_count_o}, 32'd7);

        send(ADDI);
        send(ADDI);
        send(32'h0000A001);
`ifdef CV32E40P_SEC_MARKER_RVC_EN
        chk("cj_marker", {16'd0, marker_count_o}, 32'd8);
`else
        chk("cj_marker", {16'd0, marker_count_o}, 32'd7);
`endif

        nw = 1;
        for (int i = 0; i < 1500; i++) begin
            bit v, r, f, s;
            v = $urandom_range(0, 9) < 8;
            r = $urandom_range(0, 9) < 7;
            f = $urandom_range(0, 49) == 0;
            s = $urandom_range(0, 199) != 0;
            if (nw || (!instr_valid_i && !v)) cur_word = gen();
            step(v, r, f, s);
            nw = m_acc;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
